accum_calc: RTL and testbench
=============================

ACCUM_CALC -- requirements
Module: accum_calc

Interface
REQ-001 Parameter WIDTH, default 64, operand/accumulator width in bits (>=8).
REQ-002 Parameter SCALE, default 1000000, fixed-point scale factor, 1 <= SCALE < 2^WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand/op offered this cycle.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 in_val  input  WIDTH  unsigned fixed-point operand B.
REQ-008 op  input  3  operation code: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 LOAD, 5 CLEAR, 6-7 reserved.
REQ-009 out_valid  output  1  one-cycle pulse: result and flags valid.
REQ-010 result  output  WIDTH  accumulator value after the completed operation.
REQ-011 err_ovf  output  1  overflow/underflow/truncation occurred (valid with out_valid).
REQ-012 err_div0  output  1  DIV with in_val == 0 (valid with out_valid).
REQ-013 err_op  output  1  reserved op code (valid with out_valid).

Function
REQ-014 Transfer occurs on a rising edge where in_valid && in_ready; only then are in_val and op captured.
REQ-015 States: IDLE, SHORT, DIVIDE, DONE; in_ready = 1 only in IDLE.
REQ-016 IDLE + transfer of ADD/SUB/LOAD/CLEAR/reserved/DIV-by-0 -> SHORT; MUL or DIV with B != 0 -> DIVIDE.
REQ-017 SHORT: acc updates, out_valid = 1 for exactly one cycle (cycle after transfer), -> IDLE.
REQ-018 ADD: acc = (acc + B) mod 2^WIDTH; err_ovf = carry out.
REQ-019 SUB: acc = (acc - B) mod 2^WIDTH; err_ovf = borrow (B > acc).
REQ-020 LOAD: acc = B; CLEAR: acc = 0; both flags-clear.
REQ-021 MUL: quotient of (acc * B) / SCALE, 2*WIDTH-bit numerator, divisor SCALE.
REQ-022 DIV: quotient of (acc * SCALE) / B, 2*WIDTH-bit numerator, divisor B; all division truncates toward zero, unsigned.
REQ-023 DIVIDE runs a restoring divider one quotient bit per cycle for exactly 2*WIDTH cycles, then -> DONE.
REQ-024 DONE: acc = low WIDTH bits of quotient; err_ovf = 1 iff upper WIDTH quotient bits nonzero; out_valid = 1 one cycle; -> IDLE.
REQ-025 MUL/DIV latency: out_valid in cycle 2*WIDTH+1 after transfer edge (129 for WIDTH=64); ADD etc.: cycle 1.
REQ-026 DIV with B == 0: acc unchanged, err_div0 = 1, divider not started, SHORT path.
REQ-027 Reserved op: acc unchanged, err_op = 1, SHORT path.
REQ-028 Flags not being reported are 0; at most one of err_ovf/err_div0/err_op set per result.
REQ-029 result always equals acc; holds value between operations.
REQ-030 in_val/op changes while not IDLE are ignored; in_valid held high yields back-to-back ops, one per out_valid, next accepted in the cycle after out_valid.

Reset
REQ-031 reset has priority over every state and any concurrent transfer.
REQ-032 On reset: state = IDLE, acc = 0, result = 0, out_valid = 0, all err_* = 0, in_ready = 1 in the following cycle.
REQ-033 Reset during DIVIDE aborts the operation; no out_valid is produced for it.

Structure
REQ-034 Package accum_calc_pkg holds the op-code enumeration (ADD..CLEAR, reserved) and the state enumeration.
REQ-035 Sub-module seq_divider: parametrised 2*WIDTH / WIDTH unsigned restoring divider with start/busy/done, instantiated once.
REQ-036 No combinational division or wide multiply-by-divide in the datapath besides the single acc*B / acc*SCALE product feeding seq_divider.

Verification (WIDTH=64, SCALE=1000000)
REQ-037 reset; LOAD 1500000; ADD 2250000 -> result 3750000, err_* = 0, each out_valid 1 cycle after transfer.
REQ-038 acc=3750000; MUL 2000000 -> result 7500000 exactly 129 cycles after transfer, in_ready low throughout.
REQ-039 acc=7500000; DIV 0 -> err_div0 = 1, result 7500000, out_valid next cycle; then DIV 3000000 -> result 2500000.
REQ-040 CLEAR; SUB 1 -> result 2^64-1, err_ovf = 1; op 6 -> err_op = 1, result unchanged.
REQ-041 LOAD 5000000; DIV 7 started; reset asserted 40 cycles in -> no out_valid, result 0, in_ready = 1 next cycle.
REQ-042 in_valid held high with ADD 1 for 10 ops from 0 -> ten out_valid pulses, final result 10, no op lost or duplicated.

Source files
------------

// File: rtl/accum_calc_pkg.sv
// accum_calc_pkg: op codes and FSM states shared by the accumulator calculator
package accum_calc_pkg;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_LOAD, OP_CLEAR, OP_RSV6, OP_RSV7
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_SHORT, S_DIVIDE, S_DONE} state_e;
endpackage

// File: rtl/accum_calc_seq_divider.sv
// seq_divider: unsigned restoring divider, 2W-bit numerator by W-bit divisor, one quotient bit per cycle
module seq_divider #(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [2*W-1:0] num_i,
    input  logic [W-1:0]   den_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*W-1:0] quo_o
);
    localparam int CW = $clog2(2*W) + 1;
    logic [W-1:0]   rem_q, rem_d, den_q, src_rem, dsel;
    logic [2*W-1:0] quo_q, quo_d, src_quo;
    logic [W:0]     shifted;
    logic           fits, busy_q, done_q;
    logic [CW-1:0]  cnt_q;
    // the start edge already performs the first quotient step, so 2W edges in total
    always_comb begin
        src_rem = start_i ? '0 : rem_q;
        src_quo = start_i ? num_i : quo_q;
        dsel    = start_i ? den_i : den_q;
        shifted = {src_rem, src_quo[2*W-1]};
        fits    = shifted >= {1'b0, dsel};
        rem_d   = fits ? W'(shifted - {1'b0, dsel}) : shifted[W-1:0];
        quo_d   = {src_quo[2*W-2:0], fits};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                den_q  <= den_i;
                cnt_q  <= CW'(1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(2*W-1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quo_o  = quo_q;
endmodule

// File: rtl/accum_calc.sv
// accum_calc: fixed-point accumulator with single-cycle add/sub/load/clear and sequential mul/div
module accum_calc
    import accum_calc_pkg::*;
#(
    parameter int               WIDTH = 64,
    parameter logic [WIDTH-1:0] SCALE = WIDTH'(1000000)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_val,
    input  logic [2:0]       op,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             err_ovf,
    output logic             err_div0,
    output logic             err_op
);
    state_e             state_q;
    op_e                op_c;
    logic [WIDTH-1:0]   acc_q, mul_b, den;
    logic               out_valid_q, ovf_q, div0_q, op_err_q;
    logic               is_long, div_start, div_busy, div_done;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] num, quo;
    assign op_c      = op_e'(op);
    assign is_long   = op_c == OP_MUL || (op_c == OP_DIV && in_val != '0);
    assign div_start = state_q == S_IDLE && in_valid && is_long && !div_busy;
    assign sum       = {1'b0, acc_q} + {1'b0, in_val};
    assign diff      = {1'b0, acc_q} - {1'b0, in_val};
    // one shared product: MUL divides acc*B by SCALE, DIV divides acc*SCALE by B
    assign mul_b     = op_c == OP_MUL ? in_val : SCALE;
    assign den       = op_c == OP_MUL ? SCALE : in_val;
    assign num       = (2*WIDTH)'(acc_q) * (2*WIDTH)'(mul_b);
    seq_divider #(.W(WIDTH)) u_div (
        .clk(clk), .rst(reset), .start_i(div_start), .num_i(num), .den_i(den),
        .busy_o(div_busy), .done_o(div_done), .quo_o(quo)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            div0_q      <= 1'b0;
            op_err_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            div0_q      <= 1'b0;
            op_err_q    <= 1'b0;
            case (state_q)
                S_IDLE: if (in_valid) begin
                    state_q     <= is_long ? S_DIVIDE : S_SHORT;
                    out_valid_q <= !is_long;
                    case (op_c)
                        OP_ADD:   begin acc_q <= sum[WIDTH-1:0];  ovf_q <= sum[WIDTH];  end
                        OP_SUB:   begin acc_q <= diff[WIDTH-1:0]; ovf_q <= diff[WIDTH]; end
                        OP_LOAD:  acc_q <= in_val;
                        OP_CLEAR: acc_q <= '0;
                        OP_DIV:   div0_q <= in_val == '0;
                        OP_MUL:   ;
                        default:  op_err_q <= 1'b1;
                    endcase
                end
                S_DIVIDE: if (div_done) begin
                    acc_q       <= quo[WIDTH-1:0];
                    ovf_q       <= |quo[2*WIDTH-1:WIDTH];
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign in_ready  = state_q == S_IDLE;
    assign out_valid = out_valid_q;
    assign result    = acc_q;
    assign err_ovf   = ovf_q;
    assign err_div0  = div0_q;
    assign err_op    = op_err_q;
endmodule

// File: tb/tb_accum_calc.sv
// tb_accum_calc: directed and randomized checks of accum_calc against a behavioural model
module tb_accum_calc;
    localparam logic [127:0] SC = 128'd1000000;
    logic        clk = 0, reset, in_valid, in_ready, out_valid, err_ovf, err_div0, err_op;
    logic [63:0] in_val, result;
    logic [2:0]  op;
    int total = 0, bad = 0;
    bit chk_en = 0;
    accum_calc #(.WIDTH(64), .SCALE(64'd1000000)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val),
        .op(op), .out_valid(out_valid), .result(result), .err_ovf(err_ovf),
        .err_div0(err_div0), .err_op(err_op)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic void eval(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] r, output logic [2:0] f, output bit lng);
        logic [127:0] a2, b2, q;
        logic [64:0]  s;
        a2 = {64'b0, a}; b2 = {64'b0, b}; r = a; f = 3'b000; lng = 0; q = '0;
        case (o)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[63:0]; f[2] = s[64]; end
            3'd1: begin r = a - b; f[2] = b > a; end
            3'd2: begin q = (a2 * b2) / SC; r = q[63:0]; f[2] = |q[127:64]; lng = 1; end
            3'd3: if (b == 0) f[1] = 1'b1;
                  else begin q = (a2 * SC) / b2; r = q[63:0]; f[2] = |q[127:64]; lng = 1; end
            3'd4: r = b;
            3'd5: r = '0;
            default: f[0] = 1'b1;
        endcase
    endfunction
    // model: what the outputs must be in the interval after each rising edge
    logic [63:0] m_acc = 0, p_res;
    logic [2:0]  m_flags = 0, p_flags;
    logic        m_valid = 0, m_ready = 1;
    int          left = 0;
    initial begin
        bit lng;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_acc = 0; m_valid = 0; m_ready = 1; m_flags = 0; left = 0;
            end else if (!m_ready) begin
                if (m_valid) begin m_valid = 0; m_flags = 0; m_ready = 1; end
                else begin
                    left--;
                    if (left == 0) begin m_acc = p_res; m_flags = p_flags; m_valid = 1; end
                end
            end else if (in_valid) begin
                eval(op, m_acc, in_val, p_res, p_flags, lng);
                m_ready = 0;
                if (lng) left = 128;
                else begin m_acc = p_res; m_flags = p_flags; m_valid = 1; end
            end
        end
    end
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("in_ready", 64'(in_ready), 64'(m_ready));
            chk("result", result, m_acc);
            chk("flags", 64'({err_ovf, err_div0, err_op}), 64'(m_flags));
        end
    end
    task automatic run_op(input logic [2:0] o, input logic [63:0] v, output logic [63:0] r,
                          output logic [2:0] f, output int lat, output bit rdy_seen);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 400) begin @(negedge clk); w++; end
        in_valid = 1; op = o; in_val = v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; op = 3'($urandom); in_val = {$urandom, $urandom};
        lat = 1; rdy_seen = 0;
        while (!out_valid && lat < 400) begin
            rdy_seen |= in_ready;
            @(negedge clk);
            lat++;
        end
        r = result; f = {err_ovf, err_div0, err_op};
    endtask
    initial begin
        #10_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end
    initial begin
        logic [63:0] r;
        logic [2:0]  f;
        int lat, pulses, cnt;
        bit rs;
        reset = 1; in_valid = 0; op = 0; in_val = 0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("reset_result", result, 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd1);
        chk("reset_valid", 64'(out_valid), 64'd0);
        reset = 0;
        run_op(3'd4, 64'd1500000, r, f, lat, rs);
        chk("load_lat", 64'(lat), 64'd1);
        chk("load_res", r, 64'd1500000);
        run_op(3'd0, 64'd2250000, r, f, lat, rs);
        chk("add_lat", 64'(lat), 64'd1);
        chk("add_res", r, 64'd3750000);
        chk("add_flags", 64'(f), 64'd0);
        run_op(3'd2, 64'd2000000, r, f, lat, rs);
        chk("mul_lat", 64'(lat), 64'd129);
        chk("mul_res", r, 64'd7500000);
        chk("mul_ready_low", 64'(rs), 64'd0);
        run_op(3'd3, 64'd0, r, f, lat, rs);
        chk("div0_lat", 64'(lat), 64'd1);
        chk("div0_res", r, 64'd7500000);
        chk("div0_flags", 64'(f), 64'b010);
        run_op(3'd3, 64'd3000000, r, f, lat, rs);
        chk("div_lat", 64'(lat), 64'd129);
        chk("div_res", r, 64'd2500000);
        run_op(3'd5, 64'd99, r, f, lat, rs);
        chk("clear_res", r, 64'd0);
        run_op(3'd1, 64'd1, r, f, lat, rs);
        chk("sub_res", r, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sub_flags", 64'(f), 64'b100);
        run_op(3'd6, 64'd5, r, f, lat, rs);
        chk("rsv_res", r, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rsv_flags", 64'(f), 64'b001);
        run_op(3'd4, 64'd5000000, r, f, lat, rs);
        @(negedge clk);
        in_valid = 1; op = 3'd3; in_val = 64'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        repeat (39) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("abort_result", result, 64'd0);
        chk("abort_ready", 64'(in_ready), 64'd1);
        reset = 0;
        cnt = 0;
        repeat (150) begin @(negedge clk); cnt += int'(out_valid); end
        chk("abort_no_valid", 64'(cnt), 64'd0);
        run_op(3'd5, 64'd0, r, f, lat, rs);
        @(negedge clk);
        in_valid = 1; op = 3'd0; in_val = 64'd1;
        pulses = 0; cnt = 0;
        while (pulses < 10 && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (out_valid) pulses++;
            if (pulses == 10) in_valid = 0;
        end
        in_valid = 0;
        repeat (4) begin @(negedge clk); pulses += int'(out_valid); end
        chk("b2b_pulses", 64'(pulses), 64'd10);
        chk("b2b_result", result, 64'd10);
        for (int i = 0; i < 120; i++) begin
            logic [2:0]  ro;
            logic [63:0] rv;
            int sel = int'($urandom_range(0, 15));
            ro = sel < 3 ? 3'd0 : sel < 5 ? 3'd1 : sel < 7 ? 3'd2 : sel < 9 ? 3'd3 :
                 sel < 11 ? 3'd4 : sel == 11 ? 3'd5 : sel == 12 ? 3'($urandom_range(6, 7)) : 3'd3;
            case ($urandom_range(0, 3))
                0: rv = {$urandom, $urandom};
                1: rv = 64'($urandom_range(0, 9));
                2: rv = 64'($urandom_range(1, 50_000_000));
                default: rv = 64'($urandom);
            endcase
            if (sel >= 13) rv = 0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(ro, rv, r, f, lat, rs);
        end
        repeat (3) @(negedge clk);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
